bram_stream_reader: RTL

//  Read-side engine for the simple dual-port block RAM: walks a programmed address range
//  on the RAM read port and emits the words as a valid/ready stream with a last marker.
//  It sits between the RAM read port and downstream stream consumers, and absorbs the
//  RAM's 1-cycle read latency and any consumer backpressure without losing words.

---
 rtl/bram_stream_reader_if.sv | 42 ++++
 rtl/bram_stream_reader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader_if.sv
// ---------------------------------------------------------------------------
// bram_stream_reader_if
// Groups the control, RAM read-port and output-stream signals of the
// bram_stream_reader engine.
//   start/start_addr/length : transfer request (sampled with start in IDLE)
//   busy/done               : transfer status
//   ram_addrb/ram_renb      : RAM read request (data returns one cycle later)
//   ram_doutb               : RAM read data
//   m_data/m_valid/m_last   : output stream towards the consumer
//   m_ready                 : consumer backpressure
// Modports:
//   master : the reader engine
//   slave  : the environment (controller, RAM and stream consumer)
// ---------------------------------------------------------------------------
interface bram_stream_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  length;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] ram_addrb;
  logic              ram_renb;
  logic [DATA_W-1:0] ram_doutb;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_last;
  logic              m_ready;

  modport master (
    input  start, start_addr, length, ram_doutb, m_ready,
    output busy, done, ram_addrb, ram_renb, m_data, m_valid, m_last
  );

  modport slave (
    output start, start_addr, length, ram_doutb, m_ready,
    input  busy, done, ram_addrb, ram_renb, m_data, m_valid, m_last
  );
endinterface

// File: rtl/bram_stream_reader.sv
// ---------------------------------------------------------------------------
// bram_stream_reader
// Walks a programmed address range on a block-RAM read port and emits the
// words as a valid/ready stream with a last marker. A small prefetch FIFO with
// a registered head absorbs the RAM read latency and consumer backpressure.
// Ports:
//   clkb : single clock for RAM read port and stream side
//   rstb : synchronous, active-high reset (aborts any transfer)
//   bus  : bram_stream_reader_if.master (request, status, RAM port, stream)
// ---------------------------------------------------------------------------
module bram_stream_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11,
  parameter int FIFO_D = 4
) (
  input  logic                 clkb,
  input  logic                 rstb,
  bram_stream_reader_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_D);
  // Wide enough for FIFO occupancy plus the output stage plus one in-flight read.
  localparam int CNT_W = $clog2(FIFO_D) + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              renb_q, renb_d;
  logic              pending_q, pending_last_q;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Storage holds {last, data}; the head word lives in the m_* output registers.
  logic [DATA_W:0]   mem_q [FIFO_D];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  occ_d;
  logic [CNT_W-1:0]  credit_s;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;

  logic accept_s, pop_s, issue_last_s;
  logic out_free_s, fifo_rd_s, bypass_s, fifo_wr_s;

  assign accept_s     = (state_q == IDLE) && bus.start;
  assign pop_s        = m_valid_q && bus.m_ready;
  // The read issued this cycle is the final one of the transfer.
  assign issue_last_s = renb_q && ((issued_q + LEN_W'(1)) == len_q);

  // Transfer bookkeeping: latched length, issued-read count and read address.
  always_comb begin
    len_d    = len_q;
    issued_d = issued_q;
    addr_d   = addr_q;
    if (accept_s) begin
      len_d    = bus.length;
      issued_d = {LEN_W{1'b0}};
      addr_d   = bus.start_addr;
    end else begin
      issued_d = issued_q + LEN_W'(renb_q);
      addr_d   = addr_q + ADDR_W'(renb_q);   // wraps naturally at the top of the RAM
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (bus.length == {LEN_W{1'b0}}) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (issued_d == len_q) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (pop_s && m_last_q) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Prefetch FIFO with registered head: refill the head from storage first,
  // otherwise straight from the returning RAM word when storage is empty.
  always_comb begin
    out_free_s = !m_valid_q || pop_s;
    fifo_rd_s  = out_free_s && (cnt_q != {CNT_W{1'b0}});
    bypass_s   = out_free_s && (cnt_q == {CNT_W{1'b0}}) && pending_q;
    fifo_wr_s  = pending_q && !bypass_s;

    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    if (fifo_rd_s) begin
      m_valid_d = 1'b1;
      m_data_d  = mem_q[rd_ptr_q][DATA_W-1:0];
      m_last_d  = mem_q[rd_ptr_q][DATA_W];
    end else if (bypass_s) begin
      m_valid_d = 1'b1;
      m_data_d  = bus.ram_doutb;
      m_last_d  = pending_last_q;
    end else if (out_free_s) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end else begin
      m_valid_d = 1'b1;                      // stalled: hold the head word
    end

    wr_ptr_d = wr_ptr_q + PTR_W'(fifo_wr_s);
    rd_ptr_d = rd_ptr_q + PTR_W'(fifo_rd_s);
    cnt_d    = cnt_q + CNT_W'(fifo_wr_s) - CNT_W'(fifo_rd_s);
    occ_d    = cnt_d + CNT_W'(m_valid_d);
  end

  // FSM outputs, computed from next-state values so the registered outputs
  // reflect the state they are registered into. The read of the current cycle
  // becomes next cycle's pending read, hence occ_d + renb_q as the credit.
  always_comb begin
    busy_d   = (state_d == RUN) || (state_d == DRAIN);
    done_d   = (state_d == DONE);
    credit_s = occ_d + CNT_W'(renb_q);
    renb_d   = (state_d == RUN) && (issued_d < len_d) && (credit_s < CNT_W'(FIFO_D));
  end

  // FSM state register.
  always_ff @(posedge clkb) begin
    if (rstb) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Issue-side registers and status outputs; reset drops any in-flight read.
  always_ff @(posedge clkb) begin
    if (rstb) begin
      len_q          <= {LEN_W{1'b0}};
      issued_q       <= {LEN_W{1'b0}};
      addr_q         <= {ADDR_W{1'b0}};
      renb_q         <= 1'b0;
      pending_q      <= 1'b0;
      pending_last_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      len_q          <= len_d;
      issued_q       <= issued_d;
      addr_q         <= addr_d;
      renb_q         <= renb_d;
      pending_q      <= renb_q;
      pending_last_q <= issue_last_s;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  // FIFO storage; contents are only meaningful where cnt_q says so.
  always_ff @(posedge clkb) begin
    if (fifo_wr_s) begin
      mem_q[wr_ptr_q] <= {pending_last_q, bus.ram_doutb};
    end
  end

  // FIFO pointers, occupancy and registered stream head.
  always_ff @(posedge clkb) begin
    if (rstb) begin
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= {DATA_W{1'b0}};
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ram_addrb = addr_q;
  assign bus.ram_renb  = renb_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_last    = m_last_q;

endmodule
